// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared constants, FSM state type and helpers for bus_arbiter4
package bus_pkg;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_OWN  = 1'b1
    } state_t;

    function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/bus_arbiter4_mux4.sv
// rtl/bus_arbiter4_mux4.sv - 4:1 data multiplexer steered by the arbiter's select
//
// Ports:
//   in0..in3  in   DATA_WIDTH  candidate data words
//   sel       in   SEL_W       index of the word to forward
//   y         out  DATA_WIDTH  selected word (combinational)
module bus_arbiter4_mux4
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] in0,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    input  logic [DATA_WIDTH-1:0] in3,
    input  logic [SEL_W-1:0]      sel,
    output logic [DATA_WIDTH-1:0] y
);

    always_comb begin
        y = in0;
        case (sel)
            2'd0:    y = in0;
            2'd1:    y = in1;
            2'd2:    y = in2;
            default: y = in3;
        endcase
    end

endmodule

// File: rtl/bus_arbiter4.sv
// rtl/bus_arbiter4.sv - round-robin 4-requester bus arbiter with hold limit and data mux
//
// Ports:
//   clk       in   1           rising-edge clock
//   rst_n     in   1           asynchronous active-low reset
//   req       in   4           per-requester ownership request (level)
//   done      in   4           per-requester release pulse; only the owner's bit counts
//   in0..in3  in   DATA_WIDTH  requester data
//   out       out  DATA_WIDTH  data of requester sel (combinational)
//   gnt       out  4           registered one-hot grant, zero when idle
//   sel       out  2           registered index of current or last owner
//   valid     out  1           |gnt
//   timeout   out  1           one-cycle pulse after a hold-limit-only release
module bus_arbiter4
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_HOLD   = 15,
    parameter int HOLD_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       done,
    input  logic [DATA_WIDTH-1:0] in0,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    input  logic [DATA_WIDTH-1:0] in3,
    output logic [DATA_WIDTH-1:0] out,
    output logic [NREQ-1:0]       gnt,
    output logic [SEL_W-1:0]      sel,
    output logic                  valid,
    output logic                  timeout
);

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  last_q, last_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              timeout_q, timeout_d;

    logic              owner_done;
    logic              owner_drop;
    logic              hold_hit;
    logic [NREQ-1:0]   eligible;
    logic [SEL_W:0]    pick;

    // Scan ptr+1, ptr+2, ... wrapping; the pointer itself is visited last,
    // which is what keeps a timed-out owner eligible at lowest priority.
    function automatic logic [SEL_W:0] rr_pick(input logic [NREQ-1:0]  r,
                                               input logic [SEL_W-1:0] ptr);
        logic             found;
        logic [SEL_W-1:0] win;
        logic [SEL_W-1:0] idx;
        found = 1'b0;
        win   = ptr;
        for (int i = 1; i <= NREQ; i++) begin
            idx = ptr + SEL_W'(i);
            if (!found && r[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
        owner_done = done[sel_q];
        owner_drop = !req[sel_q];
        hold_hit   = (MAX_HOLD != 0) && (cnt_q == HOLD_W'(MAX_HOLD));
        eligible   = req;
        pick       = '0;

        case (state_q)
            STATE_IDLE: begin
                pick = rr_pick(req, last_q);
                if (pick[SEL_W]) begin
                    state_d = STATE_OWN;
                    gnt_d   = onehot(pick[SEL_W-1:0]);
                    sel_d   = pick[SEL_W-1:0];
                    cnt_d   = HOLD_W'(1);
                end
            end
            STATE_OWN: begin
                if (owner_done || owner_drop || hold_hit) begin
                    last_d = sel_q;
                    // A voluntary release removes the owner from this round;
                    // a forced one leaves it in so a sole requester is re-granted.
                    if (owner_done || owner_drop) begin
                        eligible = req & ~onehot(sel_q);
                    end
                    timeout_d = hold_hit && !owner_done && !owner_drop;
                    pick      = rr_pick(eligible, sel_q);
                    if (pick[SEL_W]) begin
                        gnt_d = onehot(pick[SEL_W-1:0]);
                        sel_d = pick[SEL_W-1:0];
                        cnt_d = HOLD_W'(1);
                    end else begin
                        state_d = STATE_IDLE;
                        gnt_d   = '0;
                    end
                end else if (cnt_q != {HOLD_W{1'b1}}) begin
                    cnt_d = cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = STATE_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= STATE_IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            last_q    <= SEL_W'(NREQ - 1);
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    bus_arbiter4_mux4 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mux4 (
        .in0 (in0),
        .in1 (in1),
        .in2 (in2),
        .in3 (in3),
        .sel (sel_q),
        .y   (out)
    );

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign valid   = |gnt_q;
    assign timeout = timeout_q;

endmodule
